// File: rtl/execution_stage_mdu.sv
// execution_stage_mdu
// EX pipeline stage: operand forwarding, single-cycle ALU, branch target adder,
// iterative multiply/divide unit with HI/LO, and the EX/MEM pipeline register.
//
// Ports
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_valid/i_stall/i_flush     ID/EX valid, downstream hold, kill
//   i_rs_data, i_rt_data        register-file read values
//   i_fwd_*                     forwarding selects (0/3 RF, 1 MEM, 2 WB) and data
//   i_imm, i_shamt, i_alu_src   operand B sources (0/3 rt, 1 imm, 2 shamt)
//   i_alu_opcode, i_signed      ALU operation, signedness for ALU and MDU
//   i_mdu_op                    0 none, 1 MULT, 2 DIV, 3 MFHI, 4 MFLO
//   i_pc_next, i_wr_addr, i_ctrl  passed/used into EX/MEM
//   o_stall_req                 combinational upstream freeze while MDU iterates
//   o_valid .. o_ctrl           EX/MEM register contents
//
// MDU states
//   state   | meaning
//   IDLE    | no MULT/DIV in flight, may accept an issue
//   MUL     | shift-add multiply, one multiplier bit per cycle
//   DIV     | restoring divide, one quotient bit per cycle
//   DONE    | HI/LO written, instruction retires into EX/MEM

module execution_stage_mdu #(
   parameter int NB_ADDR       = 5,
   parameter int NB_DATA       = 32,
   parameter int NB_ALU_OPCODE = 4,
   parameter int NB_CTRL       = 5
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_valid,
   input  logic                     i_stall,
   input  logic                     i_flush,
   input  logic [NB_DATA-1:0]       i_rs_data,
   input  logic [NB_DATA-1:0]       i_rt_data,
   input  logic [1:0]               i_fwd_rs_sel,
   input  logic [1:0]               i_fwd_rt_sel,
   input  logic [NB_DATA-1:0]       i_fwd_mem_data,
   input  logic [NB_DATA-1:0]       i_fwd_wb_data,
   input  logic [NB_DATA-1:0]       i_imm,
   input  logic [NB_ADDR-1:0]       i_shamt,
   input  logic [1:0]               i_alu_src,
   input  logic [NB_ALU_OPCODE-1:0] i_alu_opcode,
   input  logic                     i_signed,
   input  logic [2:0]               i_mdu_op,
   input  logic [NB_DATA-1:0]       i_pc_next,
   input  logic [NB_ADDR-1:0]       i_wr_addr,
   input  logic [NB_CTRL-1:0]       i_ctrl,
   output logic                     o_stall_req,
   output logic                     o_valid,
   output logic [NB_DATA-1:0]       o_result,
   output logic                     o_zero,
   output logic [NB_DATA-1:0]       o_branch_addr,
   output logic [NB_DATA-1:0]       o_rt_data,
   output logic [NB_ADDR-1:0]       o_wr_addr,
   output logic [NB_CTRL-1:0]       o_ctrl
);

   localparam int SHW = $clog2(NB_DATA);
   localparam int CW  = $clog2(NB_DATA + 1);

   localparam logic [NB_ALU_OPCODE-1:0] OP_AND = NB_ALU_OPCODE'(0);
   localparam logic [NB_ALU_OPCODE-1:0] OP_OR  = NB_ALU_OPCODE'(1);
   localparam logic [NB_ALU_OPCODE-1:0] OP_ADD = NB_ALU_OPCODE'(2);
   localparam logic [NB_ALU_OPCODE-1:0] OP_XOR = NB_ALU_OPCODE'(3);
   localparam logic [NB_ALU_OPCODE-1:0] OP_SLL = NB_ALU_OPCODE'(4);
   localparam logic [NB_ALU_OPCODE-1:0] OP_SRL = NB_ALU_OPCODE'(5);
   localparam logic [NB_ALU_OPCODE-1:0] OP_SUB = NB_ALU_OPCODE'(6);
   localparam logic [NB_ALU_OPCODE-1:0] OP_SLT = NB_ALU_OPCODE'(7);
   localparam logic [NB_ALU_OPCODE-1:0] OP_SRA = NB_ALU_OPCODE'(8);
   localparam logic [NB_ALU_OPCODE-1:0] OP_LUI = NB_ALU_OPCODE'(9);
   localparam logic [NB_ALU_OPCODE-1:0] OP_NOR = NB_ALU_OPCODE'(12);

   localparam logic [2:0] MDU_MULT = 3'd1;
   localparam logic [2:0] MDU_DIV  = 3'd2;
   localparam logic [2:0] MDU_MFHI = 3'd3;
   localparam logic [2:0] MDU_MFLO = 3'd4;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdu_state_e;

   logic [NB_DATA-1:0] fwd_rs, fwd_rt, alu_b, alu_res, ex_result;
   logic [SHW-1:0]     sh;
   logic               slt;

   always_comb begin
      case (i_fwd_rs_sel)
         2'd1:    fwd_rs = i_fwd_mem_data;
         2'd2:    fwd_rs = i_fwd_wb_data;
         default: fwd_rs = i_rs_data;
      endcase
      case (i_fwd_rt_sel)
         2'd1:    fwd_rt = i_fwd_mem_data;
         2'd2:    fwd_rt = i_fwd_wb_data;
         default: fwd_rt = i_rt_data;
      endcase
      case (i_alu_src)
         2'd1:    alu_b = i_imm;
         2'd2:    alu_b = {{(NB_DATA-NB_ADDR){1'b0}}, i_shamt};
         default: alu_b = fwd_rt;
      endcase
   end

   assign sh  = alu_b[SHW-1:0];
   assign slt = i_signed ? ($signed(fwd_rs) < $signed(alu_b)) : (fwd_rs < alu_b);

   always_comb begin
      alu_res = '0;
      case (i_alu_opcode)
         OP_AND:  alu_res = fwd_rs & alu_b;
         OP_OR:   alu_res = fwd_rs | alu_b;
         OP_ADD:  alu_res = fwd_rs + alu_b;
         OP_XOR:  alu_res = fwd_rs ^ alu_b;
         OP_SLL:  alu_res = fwd_rs << sh;
         OP_SRL:  alu_res = fwd_rs >> sh;
         OP_SUB:  alu_res = fwd_rs - alu_b;
         OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, slt};
         OP_SRA:  alu_res = $signed(fwd_rs) >>> sh;
         OP_LUI:  alu_res = alu_b << (NB_DATA/2);
         OP_NOR:  alu_res = ~(fwd_rs | alu_b);
         default: alu_res = '0;
      endcase
   end

   // MDU datapath
   mdu_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NB_DATA-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
   logic [NB_DATA-1:0] hi_q, hi_d, lo_q, lo_d;
   logic               neg_q, neg_d, rem_neg_q, rem_neg_d, dbz_q, dbz_d;
   logic               issue, a_neg, b_neg, div_ok;
   logic [NB_DATA-1:0] a_abs, b_abs;
   logic [NB_DATA:0]   mul_sum, div_shift, div_diff;
   logic [NB_DATA-1:0] mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
   logic [2*NB_DATA-1:0] prod_s;

   assign a_neg = i_signed & fwd_rs[NB_DATA-1];
   assign b_neg = i_signed & fwd_rt[NB_DATA-1];
   assign a_abs = a_neg ? -fwd_rs : fwd_rs;
   assign b_abs = b_neg ? -fwd_rt : fwd_rt;

   // Multiply: acc_hi accumulates, acc_lo holds the multiplier and collects product low bits.
   assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
   assign mul_hi_nx = mul_sum[NB_DATA:1];
   assign mul_lo_nx = {mul_sum[0], acc_lo_q[NB_DATA-1:1]};
   assign prod_s    = neg_q ? -{mul_hi_nx, mul_lo_nx} : {mul_hi_nx, mul_lo_nx};

   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
   assign div_shift = {acc_hi_q, acc_lo_q[NB_DATA-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_ok    = ~div_diff[NB_DATA];
   assign div_hi_nx = div_ok ? div_diff[NB_DATA-1:0] : div_shift[NB_DATA-1:0];
   assign div_lo_nx = {acc_lo_q[NB_DATA-2:0], div_ok};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      opb_d     = opb_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      issue     = 1'b0;
      if (i_flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid && (i_mdu_op == MDU_MULT || i_mdu_op == MDU_DIV)) begin
                  issue     = 1'b1;
                  acc_hi_d  = '0;
                  acc_lo_d  = a_abs;
                  opb_d     = b_abs;
                  cnt_d     = CW'(NB_DATA);
                  neg_d     = a_neg ^ b_neg;
                  rem_neg_d = a_neg;
                  dbz_d     = (fwd_rt == '0);
                  state_d   = (i_mdu_op == MDU_MULT) ? ST_MUL : ST_DIV;
               end
            end
            ST_MUL: begin
               acc_hi_d = mul_hi_nx;
               acc_lo_d = mul_lo_nx;
               cnt_d    = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  {hi_d, lo_d} = prod_s;
                  state_d      = ST_DONE;
               end
            end
            ST_DIV: begin
               acc_hi_d = div_hi_nx;
               acc_lo_d = div_lo_nx;
               cnt_d    = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  hi_d    = rem_neg_q ? -div_hi_nx : div_hi_nx;
                  // Divide by zero yields an all-ones quotient regardless of sign.
                  lo_d    = dbz_q ? '1 : (neg_q ? -div_lo_nx : div_lo_nx);
                  state_d = ST_DONE;
               end
            end
            default: begin
               if (!i_stall) state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign o_stall_req = issue | (state_q == ST_MUL) | (state_q == ST_DIV);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         opb_q     <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         opb_q     <= opb_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      case (i_mdu_op)
         MDU_MFHI: ex_result = hi_q;
         MDU_MFLO: ex_result = lo_q;
         default:  ex_result = alu_res;
      endcase
   end

   // EX/MEM register: reset > flush > hold > bubble while MDU busy > load
   always_ff @(posedge i_clock) begin
      if (i_reset || i_flush || (!i_stall && o_stall_req)) begin
         o_valid       <= 1'b0;
         o_result      <= '0;
         o_zero        <= 1'b0;
         o_branch_addr <= '0;
         o_rt_data     <= '0;
         o_wr_addr     <= '0;
         o_ctrl        <= '0;
      end else if (!i_stall) begin
         o_valid       <= i_valid;
         o_result      <= ex_result;
         o_zero        <= (alu_res == '0);
         o_branch_addr <= i_pc_next + i_imm;
         o_rt_data     <= fwd_rt;
         o_wr_addr     <= i_wr_addr;
         o_ctrl        <= i_valid ? i_ctrl : '0;
      end
   end

endmodule

// File: tb/tb_execution_stage_mdu.sv
module tb_execution_stage_mdu;
   localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_XOR = 4'd3;
   localparam logic [3:0] ALU_SLL = 4'd4, ALU_SUB = 4'd6, ALU_SLT = 4'd7;

   logic        i_clock, i_reset, i_valid, i_stall, i_flush, i_signed;
   logic [31:0] i_rs_data, i_rt_data, i_fwd_mem_data, i_fwd_wb_data, i_imm, i_pc_next;
   logic [1:0]  i_fwd_rs_sel, i_fwd_rt_sel, i_alu_src;
   logic [4:0]  i_shamt, i_wr_addr, i_ctrl;
   logic [3:0]  i_alu_opcode;
   logic [2:0]  i_mdu_op;
   logic        o_stall_req, o_valid, o_zero;
   logic [31:0] o_result, o_branch_addr, o_rt_data;
   logic [4:0]  o_wr_addr, o_ctrl;

   execution_stage_mdu #(.NB_ADDR(5), .NB_DATA(32), .NB_ALU_OPCODE(4), .NB_CTRL(5)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
      .i_flush(i_flush), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
      .i_fwd_rs_sel(i_fwd_rs_sel), .i_fwd_rt_sel(i_fwd_rt_sel),
      .i_fwd_mem_data(i_fwd_mem_data), .i_fwd_wb_data(i_fwd_wb_data), .i_imm(i_imm),
      .i_shamt(i_shamt), .i_alu_src(i_alu_src), .i_alu_opcode(i_alu_opcode),
      .i_signed(i_signed), .i_mdu_op(i_mdu_op), .i_pc_next(i_pc_next),
      .i_wr_addr(i_wr_addr), .i_ctrl(i_ctrl), .o_stall_req(o_stall_req),
      .o_valid(o_valid), .o_result(o_result), .o_zero(o_zero),
      .o_branch_addr(o_branch_addr), .o_rt_data(o_rt_data), .o_wr_addr(o_wr_addr),
      .o_ctrl(o_ctrl)
   );

   typedef struct packed {
      logic [31:0] result;
      logic        zero;
      logic [31:0] rt;
      logic [31:0] br;
      logic [4:0]  wr;
      logic [4:0]  ctrl;
      logic        full;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_hi, last_lo;

   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   task automatic idle_inputs();
      i_valid = 0; i_signed = 0; i_rs_data = 0; i_rt_data = 0; i_fwd_mem_data = 0;
      i_fwd_wb_data = 0; i_imm = 0; i_pc_next = 0; i_fwd_rs_sel = 0; i_fwd_rt_sel = 0;
      i_alu_src = 0; i_shamt = 0; i_wr_addr = 0; i_ctrl = 0; i_alu_opcode = ALU_AND;
      i_mdu_op = 0;
   endtask

   task automatic set_alu(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      idle_inputs();
      i_valid = 1; i_alu_opcode = op; i_rs_data = rs; i_rt_data = rt;
      i_wr_addr = 5'd9; i_ctrl = 5'b00011;
   endtask

   function automatic exp_t mk(input logic [31:0] r);
      exp_t x;
      x = '0;
      x.result = r;
      return x;
   endfunction

   task automatic test_reset();
      i_reset = 1; i_stall = 0; i_flush = 0;
      idle_inputs();
      step(); step();
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      n_vec++; if (o_result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", o_result); end
      n_vec++; if (o_stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", o_stall_req); end
      n_vec++; if (o_ctrl !== 5'd0 || o_branch_addr !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %h/%h expected 0/0", o_ctrl, o_branch_addr); end
      i_reset = 0;
      step();
   endtask

   task automatic test_forwarding();
      logic [1:0]  rs_sel[6] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
      logic [1:0]  rt_sel[6] = '{2'd1, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2};
      logic [1:0]  src[6]    = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
      logic [3:0]  op[6]     = '{ALU_ADD, ALU_SUB, ALU_ADD, ALU_SLL, ALU_SUB, ALU_SLT};
      logic [31:0] res[6]    = '{32'd12, 32'd980, 32'd8, 32'd20, 32'd0, 32'd1};
      logic [31:0] rtv[6]    = '{32'd7, 32'd20, 32'd20, 32'd20, 32'd7, 32'd1000};
      for (int k = 0; k < 6; k++) begin
         idle_inputs();
         i_valid = 1; i_rs_data = 5; i_rt_data = 20; i_fwd_mem_data = 7; i_fwd_wb_data = 1000;
         i_imm = 3; i_shamt = 2; i_pc_next = 100; i_signed = 1;
         i_fwd_rs_sel = rs_sel[k]; i_fwd_rt_sel = rt_sel[k]; i_alu_src = src[k];
         i_alu_opcode = op[k]; i_wr_addr = 5'(k + 1); i_ctrl = 5'b10101;
         e = mk(res[k]); e.zero = (res[k] == 0); e.rt = rtv[k]; e.br = 32'd103;
         e.wr = 5'(k + 1); e.ctrl = 5'b10101; e.full = 1;
         sb.push_back(e);
         step();
         n_vec++;
         if (o_valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL fwd%0d_valid: got %b, queue %0d, expected valid output", k, o_valid, sb.size());
         end else begin
            e = sb.pop_front();
            n_vec++; if (o_result !== e.result) begin n_err++; $display("FAIL fwd%0d_result: got %h expected %h", k, o_result, e.result); end
            n_vec++; if (o_zero !== e.zero) begin n_err++; $display("FAIL fwd%0d_zero: got %b expected %b", k, o_zero, e.zero); end
            n_vec++; if (o_rt_data !== e.rt) begin n_err++; $display("FAIL fwd%0d_rt: got %h expected %h", k, o_rt_data, e.rt); end
            n_vec++; if (o_branch_addr !== e.br || o_wr_addr !== e.wr || o_ctrl !== e.ctrl) begin
               n_err++; $display("FAIL fwd%0d_fields: got br %h wr %0d ctrl %b expected %h %0d %b", k, o_branch_addr, o_wr_addr, o_ctrl, e.br, e.wr, e.ctrl);
            end
         end
      end
      idle_inputs();
      step();
      n_vec++; if (o_valid !== 1'b0 || o_ctrl !== 5'd0) begin n_err++; $display("FAIL fwd_bubble: got valid %b ctrl %b expected 0/0", o_valid, o_ctrl); end
   endtask

   task automatic test_mdu_ops();
      logic [2:0]  op[9]  = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
      logic        sgn[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] a[9]   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9, 32'd9,
                              32'h80000000, 32'd100, 32'd7, 32'hFFFFFFF7};
      logic [31:0] b[9]   = '{32'd4, 32'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7,
                              32'hFFFFFFFE, 32'd0};
      logic [31:0] ehi[9] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd9, 32'd0, 32'd2,
                              32'd1, 32'hFFFFFFF7};
      logic [31:0] elo[9] = '{32'hFFFFFFF4, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'h80000000, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF};
      int cyc;
      for (int k = 0; k < 9; k++) begin
         set_alu(ALU_ADD, a[k], b[k]);
         i_mdu_op = op[k]; i_signed = sgn[k];
         sb.push_back(mk(a[k] + b[k]));
         #1;
         cyc = 0;
         while (o_stall_req === 1'b1 && cyc < 100) begin cyc++; step(); end
         n_vec++; if (cyc != 33) begin n_err++; $display("FAIL mdu%0d_stall_cycles: got %0d expected 33", k, cyc); end
         n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mdu%0d_bubble: got valid %b expected 0", k, o_valid); end
         step();
         for (int r = 0; r < 3; r++) begin
            if (r == 1) begin set_alu(ALU_ADD, 0, 0); i_mdu_op = 3'd4; sb.push_back(mk(elo[k])); step(); end
            if (r == 2) begin set_alu(ALU_ADD, 0, 0); i_mdu_op = 3'd3; sb.push_back(mk(ehi[k])); step(); end
            n_vec++;
            if (o_valid !== 1'b1 || sb.size() == 0) begin
               n_err++; $display("FAIL mdu%0d_out%0d_valid: got %b, queue %0d, expected valid output", k, r, o_valid, sb.size());
            end else begin
               e = sb.pop_front();
               n_vec++; if (o_result !== e.result) begin n_err++; $display("FAIL mdu%0d_out%0d_result: got %h expected %h", k, r, o_result, e.result); end
            end
         end
         last_hi = ehi[k]; last_lo = elo[k];
      end
      idle_inputs();
      step();
   endtask

   task automatic test_stall_flush();
      set_alu(ALU_ADD, 10, 20);
      i_wr_addr = 5'd3;
      sb.push_back(mk(32'd30));
      step();
      n_vec++;
      if (o_valid !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL stall_load_valid: got %b expected 1", o_valid); end
      else begin e = sb.pop_front(); n_vec++; if (o_result !== e.result) begin n_err++; $display("FAIL stall_load: got %h expected %h", o_result, e.result); end end
      i_stall = 1;
      set_alu(ALU_ADD, 1, 1);
      i_wr_addr = 5'd4;
      for (int c = 0; c < 3; c++) begin
         step();
         n_vec++;
         if (o_result !== 32'd30 || o_valid !== 1'b1 || o_wr_addr !== 5'd3) begin
            n_err++; $display("FAIL stall_hold%0d: got %h/%b/%0d expected 30/1/3", c, o_result, o_valid, o_wr_addr);
         end
      end
      i_stall = 0;
      sb.push_back(mk(32'd2));
      step();
      n_vec++;
      if (o_valid !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL stall_release_valid: got %b expected 1", o_valid); end
      else begin e = sb.pop_front(); n_vec++; if (o_result !== e.result) begin n_err++; $display("FAIL stall_release: got %h expected %h", o_result, e.result); end end
      i_flush = 1; i_stall = 1;
      set_alu(ALU_ADD, 4, 4);
      step();
      i_flush = 0; i_stall = 0;
      n_vec++;
      if (o_valid !== 1'b0 || o_ctrl !== 5'd0 || o_result !== 32'd0) begin
         n_err++; $display("FAIL flush: got valid %b ctrl %b result %h expected 0/0/0", o_valid, o_ctrl, o_result);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_flush_div();
      set_alu(ALU_ADD, 100, 3);
      i_mdu_op = 3'd2; i_signed = 1;
      #1;
      repeat (9) step();
      n_vec++; if (o_stall_req !== 1'b1) begin n_err++; $display("FAIL fdiv_busy: got %b expected 1", o_stall_req); end
      i_flush = 1;
      step();
      i_flush = 0;
      idle_inputs();
      #1;
      n_vec++; if (o_stall_req !== 1'b0 || o_valid !== 1'b0) begin n_err++; $display("FAIL fdiv_abort: got stall %b valid %b expected 0/0", o_stall_req, o_valid); end
      for (int r = 0; r < 2; r++) begin
         set_alu(ALU_ADD, 0, 0);
         i_mdu_op = (r == 0) ? 3'd3 : 3'd4;
         sb.push_back(mk((r == 0) ? last_hi : last_lo));
         step();
         n_vec++;
         if (o_valid !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL fdiv_hilo%0d_valid: got %b expected 1", r, o_valid); end
         else begin e = sb.pop_front(); n_vec++; if (o_result !== e.result) begin n_err++; $display("FAIL fdiv_hilo%0d: got %h expected %h", r, o_result, e.result); end end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid_mult();
      set_alu(ALU_ADD, 5, 6);
      i_mdu_op = 3'd1;
      repeat (5) step();
      i_reset = 1;
      step();
      i_reset = 0;
      idle_inputs();
      #1;
      n_vec++;
      if (o_valid !== 1'b0 || o_result !== 32'd0 || o_stall_req !== 1'b0) begin
         n_err++; $display("FAIL rst_mult: got valid %b result %h stall %b expected 0/0/0", o_valid, o_result, o_stall_req);
      end
      for (int r = 0; r < 2; r++) begin
         set_alu(ALU_ADD, 0, 0);
         i_mdu_op = (r == 0) ? 3'd3 : 3'd4;
         sb.push_back(mk(32'd0));
         step();
         n_vec++;
         if (o_valid !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL rst_hilo%0d_valid: got %b expected 1", r, o_valid); end
         else begin e = sb.pop_front(); n_vec++; if (o_result !== e.result) begin n_err++; $display("FAIL rst_hilo%0d: got %h expected %h", r, o_result, e.result); end end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops[5] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND};
      logic [31:0] a, b, bsel, r;
      int sel;
      for (int k = 0; k < 24; k++) begin
         sel = $urandom_range(0, 4);
         a = $urandom(); b = $urandom();
         if (k == 5) b = a;
         idle_inputs();
         i_valid = 1; i_rs_data = a; i_rt_data = b; i_alu_opcode = ops[sel];
         i_imm = $urandom(); i_pc_next = $urandom(); i_alu_src = 2'($urandom_range(0, 1));
         if (k == 5) begin sel = 1; i_alu_opcode = ALU_SUB; i_alu_src = 0; end
         bsel = (i_alu_src == 2'd1) ? i_imm : b;
         case (sel)
            0: r = a + bsel;
            1: r = a - bsel;
            2: r = a ^ bsel;
            3: r = a | bsel;
            default: r = a & bsel;
         endcase
         e = mk(r); e.zero = (r == 0); e.rt = b; e.br = i_pc_next + i_imm;
         e.wr = 5'd0; e.ctrl = 5'd0; e.full = 1;
         sb.push_back(e);
         step();
         n_vec++;
         if (o_valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL b2b%0d_valid: got %b expected 1", k, o_valid);
         end else begin
            e = sb.pop_front();
            n_vec++; if (o_result !== e.result || o_zero !== e.zero) begin n_err++; $display("FAIL b2b%0d_result: got %h/%b expected %h/%b", k, o_result, o_zero, e.result, e.zero); end
            n_vec++; if (o_branch_addr !== e.br || o_rt_data !== e.rt) begin n_err++; $display("FAIL b2b%0d_br_rt: got %h/%h expected %h/%h", k, o_branch_addr, o_rt_data, e.br, e.rt); end
         end
      end
      idle_inputs();
      step();
   endtask

   initial begin
      i_reset = 1; i_stall = 0; i_flush = 0;
      idle_inputs();
      last_hi = 0; last_lo = 0;
      test_reset();
      test_forwarding();
      test_mdu_ops();
      test_stall_flush();
      test_flush_div();
      test_reset_mid_mult();
      test_back_to_back();
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
